// File: rtl/flappy_game_ctrl.sv
// -----------------------------------------------------------------------------
// flappy_game_ctrl
//
// Game-flow controller sitting between the jump input decoders (keyboard,
// Q-learning agent, ...) and the game-object modules (bird, pipes,
// background). It provides:
//   - a free-running frame tick (one pulse every CLK_HZ/FPS clocks),
//   - an N-way jump source selector with rising-edge detection,
//   - a jump pulse stretcher that holds jump for JUMP_HOLD frame ticks,
//   - an IDLE / PLAY / DEAD game state machine,
//   - a reset level for the game objects (high while IDLE),
//   - high-score tracking across games.
//
// Optional feature macro: FLAPPY_AUTO_RESTART_EN
//   Defined     : after the DEAD countdown the game returns to IDLE on its own,
//                 and IDLE starts PLAY on the next frame tick without a jump
//                 edge (unattended training). A jump edge still starts play
//                 early from IDLE.
//   Not defined : leaving DEAD and leaving IDLE both need a jump edge.
//
// Ports
//   clk         in   1        system clock
//   rst         in   1        asynchronous reset, active-high
//   jump_src    in   N_SRC    raw jump request levels (clk domain)
//   src_sel     in   SEL_W    active source index; out-of-range selects none
//   is_collide  in   1        collision flag from collision detection
//   score       in   SCORE_W  current score from the pipe generator
//   frame_tick  out  1        one-cycle pulse every TICK_DIV clocks
//   jump        out  1        stretched jump level to the game objects
//   game_rst    out  1        reset level for the game objects (1 in IDLE)
//   state       out  2        game state: 0 IDLE, 1 PLAY, 2 DEAD
//   high_score  out  SCORE_W  best score seen since rst
//
// Handshake note: there is no valid/ready traffic here. jump_src entries are
// plain levels; only their rising edges (on the selected source) count as
// requests. frame_tick is a single-cycle strobe with no acknowledge.
// -----------------------------------------------------------------------------
module flappy_game_ctrl #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int FPS         = 60,
    parameter int N_SRC       = 2,
    parameter int JUMP_HOLD   = 1,
    parameter int DEAD_FRAMES = 30,
    parameter int SCORE_W     = 7,
    localparam int SEL_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   jump_src,
    input  logic [SEL_W-1:0]   src_sel,
    input  logic               is_collide,
    input  logic [SCORE_W-1:0] score,
    output logic               frame_tick,
    output logic               jump,
    output logic               game_rst,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] high_score
);

    localparam int TICK_DIV = CLK_HZ / FPS;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W   = $clog2(JUMP_HOLD + 1);
    localparam int DEAD_W   = $clog2(DEAD_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Frame tick generator: free-running in every game state.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] tick_cnt;
    logic             tick_last;

    assign tick_last = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt   <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= tick_last;
            tick_cnt   <= tick_last ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Source select and rising-edge detect.
    // A change of src_sel would otherwise look like an edge when the new
    // source is already high, so the edge is masked in that cycle and the
    // edge register is reloaded from the new source.
    // -------------------------------------------------------------------------
    logic             sel;
    logic             sel_q;
    logic [SEL_W-1:0] src_sel_q;
    logic             sel_changed;
    logic             jump_edge;

    always_comb begin
        sel = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                sel = jump_src[i];
            end
        end
    end

    assign sel_changed = (src_sel != src_sel_q);
    assign jump_edge   = sel & ~sel_q & ~sel_changed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= 1'b0;
            src_sel_q <= '0;
        end else begin
            sel_q     <= sel;
            src_sel_q <= src_sel;
        end
    end

    // -------------------------------------------------------------------------
    // Game state machine with jump stretcher, death countdown and high score.
    // -------------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic                jump_d;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_d;
    logic [DEAD_W-1:0]   dead_cnt;
    logic [DEAD_W-1:0]   dead_d;
    logic [SCORE_W-1:0]  high_d;
    logic                dead_done;

    assign dead_done = (dead_cnt == DEAD_W'(DEAD_FRAMES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            jump       <= 1'b0;
            hold_cnt   <= '0;
            dead_cnt   <= '0;
            high_score <= '0;
        end else begin
            state_q    <= state_d;
            jump       <= jump_d;
            hold_cnt   <= hold_d;
            dead_cnt   <= dead_d;
            high_score <= high_d;
        end
    end

    always_comb begin
        state_d = state_q;
        jump_d  = jump;
        hold_d  = hold_cnt;
        dead_d  = dead_cnt;
        high_d  = high_score;

        case (state_q)
            ST_IDLE: begin
                // The edge that starts a game is consumed by the start and
                // never reaches the bird as a jump.
                jump_d = 1'b0;
                hold_d = '0;
                dead_d = '0;
                if (jump_edge) begin
                    state_d = ST_PLAY;
                end
`ifdef FLAPPY_AUTO_RESTART_EN
                else if (frame_tick) begin
                    state_d = ST_PLAY;
                end
`endif
            end

            ST_PLAY: begin
                // Covers both ordinary frames and the final frame of a game.
                if (frame_tick && (score > high_score)) begin
                    high_d = score;
                end

                if (frame_tick && is_collide) begin
                    // Death outranks a simultaneous jump request.
                    state_d = ST_DEAD;
                    jump_d  = 1'b0;
                    hold_d  = '0;
                    dead_d  = '0;
                end else if (sel_changed) begin
                    jump_d = 1'b0;
                    hold_d = '0;
                end else if (jump_edge) begin
                    // New request or retrigger; an edge on a tick cycle
                    // reloads rather than being decremented.
                    jump_d = 1'b1;
                    hold_d = HOLD_W'(JUMP_HOLD);
                end else if (frame_tick && jump) begin
                    // hold_cnt is always >= 1 while jump is high.
                    hold_d = hold_cnt - HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(1)) begin
                        jump_d = 1'b0;
                    end
                end
            end

            ST_DEAD: begin
                jump_d = 1'b0;
                hold_d = '0;
                if (dead_done) begin
`ifdef FLAPPY_AUTO_RESTART_EN
                    state_d = ST_IDLE;
`else
                    if (jump_edge) begin
                        state_d = ST_IDLE;
                    end
`endif
                end else if (frame_tick) begin
                    // Edges are deliberately ignored during the countdown.
                    dead_d = dead_cnt + DEAD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                jump_d  = 1'b0;
                hold_d  = '0;
                dead_d  = '0;
            end
        endcase
    end

    // game_rst is decoded straight from the state register so it falls in the
    // same cycle the state reads PLAY.
    assign game_rst = (state_q == ST_IDLE);
    assign state    = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flappy_game_ctrl
//
// Bench for flappy_game_ctrl with CLK_HZ=600, FPS=60 (TICK_DIV=10),
// N_SRC=3 (so src_sel=3 is an out-of-range selection), JUMP_HOLD=1,
// DEAD_FRAMES=3, SCORE_W=7.
// Cycle n is the interval after the n-th rising edge following reset release.
// -----------------------------------------------------------------------------
module tb_flappy_game_ctrl;

    localparam int TD   = 10;
    localparam int NS   = 3;
    localparam int SELW = 2;
    localparam int JH   = 1;
    localparam int DF   = 3;
    localparam int SW   = 7;
`ifdef FLAPPY_AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NS-1:0]   jump_src = '0;
    logic [SELW-1:0] src_sel = '0;
    logic            is_collide = 1'b0;
    logic [SW-1:0]   score = '0;
    logic            frame_tick;
    logic            jump;
    logic            game_rst;
    logic [1:0]      state;
    logic [SW-1:0]   high_score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flappy_game_ctrl #(
        .CLK_HZ(600), .FPS(60), .N_SRC(NS), .JUMP_HOLD(JH),
        .DEAD_FRAMES(DF), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .jump_src(jump_src), .src_sel(src_sel),
        .is_collide(is_collide), .score(score), .frame_tick(frame_tick),
        .jump(jump), .game_rst(game_rst), .state(state), .high_score(high_score)
    );

    // ---------------- reference model ----------------
    // Game rules in integer form: cycle count since reset gives the tick,
    // mode 0/1/2 is idle/play/dead, hold counts remaining frames of a jump.
    int m_n, m_state, m_hold, m_dead, m_hs, m_selq, m_prevsel;
    bit m_tick, m_jump;

    always @(posedge clk or posedge rst) begin : model
        int s, sel, ns, nh, nd, nhs;
        bit chg, edg, nj;
        if (rst) begin
            m_n <= 0; m_tick <= 0; m_state <= 0; m_jump <= 0; m_hold <= 0;
            m_dead <= 0; m_hs <= 0; m_selq <= 0; m_prevsel <= 0;
        end else begin
            s   = int'(src_sel);
            sel = (s < NS) ? int'(jump_src[s]) : 0;
            chg = (s != m_prevsel);
            edg = !chg && (sel == 1) && (m_selq == 0);
            ns = m_state; nj = m_jump; nh = m_hold; nd = m_dead; nhs = m_hs;
            if (m_state == 0) begin
                if (edg || (AUTO && m_tick)) ns = 1;
            end else if (m_state == 1) begin
                if (m_tick && int'(score) > m_hs) nhs = int'(score);
                if (m_tick && is_collide) begin
                    ns = 2; nj = 0; nh = 0; nd = 0;
                end else if (chg) begin
                    nj = 0; nh = 0;
                end else if (edg) begin
                    nj = 1; nh = JH;
                end else if (m_tick && m_jump) begin
                    nh = m_hold - 1;
                    nj = (nh > 0);
                end
            end else begin
                if (m_dead >= DF) begin
                    if (edg || AUTO) ns = 0;
                end else if (m_tick) begin
                    nd = m_dead + 1;
                end
            end
            m_n      <= m_n + 1;
            m_tick   <= ((m_n + 1) % TD) == 0;
            m_state  <= ns;
            m_jump   <= nj;
            m_hold   <= nh;
            m_dead   <= nd;
            m_hs     <= nhs;
            m_selq   <= sel;
            m_prevsel <= s;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; jump_src = '0; src_sel = '0; is_collide = 1'b0; score = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance to the falling edge inside cycle n (bounded).
    task automatic wait_cycle(input int n);
        int guard = 0;
        while (m_n < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (m_n != n) begin
            errors++;
            $display("FAIL wait_cycle reached %0d required %0d", m_n, n);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
        checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL rst_game_rst got %b want 1", game_rst); end
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL rst_jump got %b want 0", jump); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", frame_tick); end
        checks++; if (high_score !== '0) begin errors++; $display("FAIL rst_hs got %0d want 0", high_score); end
        for (int c = 1; c <= 35; c++) begin
            wait_cycle(c);
            checks++;
            if (frame_tick !== ((c % TD) == 0)) begin
                errors++; $display("FAIL idle_tick cycle %0d got %b want %b", c, frame_tick, (c % TD) == 0);
            end
            if (c <= 10) begin
                checks++;
                if (state !== 2'd0 || game_rst !== 1'b1 || jump !== 1'b0) begin
                    errors++; $display("FAIL idle_outputs cycle %0d state %0d game_rst %b jump %b", c, state, game_rst, jump);
                end
            end
        end
    endtask

    task automatic test_start_jump();
        do_reset();
        wait_cycle(5);  jump_src = 3'b001;
        wait_cycle(6);  jump_src = 3'b000;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state got %0d want 1", state); end
        checks++; if (game_rst !== 1'b0) begin errors++; $display("FAIL start_game_rst got %b want 0", game_rst); end
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL start_no_jump got %b want 0", jump); end
        wait_cycle(42); jump_src = 3'b001;
        wait_cycle(43); jump_src = 3'b000;
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL jump_rise got %b want 1", jump); end
        wait_cycle(50);
        checks++; if (jump !== 1'b1 || frame_tick !== 1'b1) begin errors++; $display("FAIL jump_hold_tick jump %b tick %b want 1 1", jump, frame_tick); end
        wait_cycle(51);
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL jump_fall got %b want 0", jump); end
    endtask

    task automatic test_collide();
        // Continues from test_start_jump at cycle 51, game in PLAY.
        wait_cycle(52); score = 7'd5;
        wait_cycle(55); is_collide = 1'b1;
        wait_cycle(59);
        checks++; if (state !== 2'd1 || high_score !== 7'd0) begin errors++; $display("FAIL pre_collide state %0d hs %0d want 1 0", state, high_score); end
        wait_cycle(61); is_collide = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL collide_state got %0d want 2", state); end
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL collide_jump got %b want 0", jump); end
        checks++; if (high_score !== 7'd5) begin errors++; $display("FAIL collide_hs got %0d want 5", high_score); end
        for (int k = 0; k < 4; k++) begin
            wait_cycle(65 + 8 * k); jump_src = 3'b001;
            wait_cycle(66 + 8 * k); jump_src = 3'b000;
        end
        wait_cycle(91);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL dead_ignore got %0d want 2", state); end
        wait_cycle(92); jump_src = 3'b001;
        wait_cycle(93); jump_src = 3'b000;
        checks++; if (state !== 2'd0 || game_rst !== 1'b1) begin errors++; $display("FAIL restart state %0d game_rst %b want 0 1", state, game_rst); end
        checks++; if (high_score !== 7'd5) begin errors++; $display("FAIL restart_hs got %0d want 5", high_score); end
    endtask

    task automatic test_auto_restart();
        do_reset();
        wait_cycle(3);  jump_src = 3'b001;
        wait_cycle(4);  jump_src = 3'b000;
        wait_cycle(5);  score = 7'd9;
        wait_cycle(15); is_collide = 1'b1;
        wait_cycle(21); is_collide = 1'b0;
        checks++; if (state !== 2'd2 || high_score !== 7'd9) begin errors++; $display("FAIL auto_dead state %0d hs %0d want 2 9", state, high_score); end
        wait_cycle(51);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL auto_countdown got %0d want 2", state); end
        wait_cycle(52);
        checks++; if (state !== 2'd0 || game_rst !== 1'b1) begin errors++; $display("FAIL auto_idle state %0d game_rst %b want 0 1", state, game_rst); end
        wait_cycle(60);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL auto_wait got %0d want 0", state); end
        wait_cycle(61); score = 7'd4;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL auto_play got %0d want 1", state); end
        wait_cycle(65); is_collide = 1'b1;
        wait_cycle(71); is_collide = 1'b0;
        checks++; if (state !== 2'd2 || high_score !== 7'd9) begin errors++; $display("FAIL auto_hs state %0d hs %0d want 2 9", state, high_score); end
    endtask

    task automatic test_src_switch();
        do_reset();
        wait_cycle(3);  jump_src = 3'b001;
        wait_cycle(4);  jump_src = 3'b000;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL sw_start got %0d want 1", state); end
        wait_cycle(5);  jump_src = 3'b010;
        wait_cycle(7);  src_sel = 2'd1;
        wait_cycle(9);
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL sw_no_jump got %b want 0", jump); end
        wait_cycle(12);
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL sw_no_jump_late got %b want 0", jump); end
        wait_cycle(13); jump_src = 3'b000;
        wait_cycle(14); jump_src = 3'b010;
        wait_cycle(15);
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL sw_new_edge got %b want 1", jump); end
        wait_cycle(21);
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL sw_hold_end got %b want 0", jump); end
        wait_cycle(25); src_sel = 2'd3; jump_src = 3'b000;
        wait_cycle(27); jump_src = 3'b011;
        wait_cycle(28); jump_src = 3'b000;
        wait_cycle(29);
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL sel_none_a got %b want 0", jump); end
        wait_cycle(31); jump_src = 3'b111;
        wait_cycle(32); jump_src = 3'b000;
        wait_cycle(33);
        checks++; if (jump !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL sel_none_b jump %b state %0d want 0 1", jump, state); end
        wait_cycle(35); src_sel = 2'd0;
        wait_cycle(37); jump_src = 3'b001;
        wait_cycle(38); jump_src = 3'b000;
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL sw_rejump got %b want 1", jump); end
        wait_cycle(39); src_sel = 2'd1;
        wait_cycle(40);
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL sw_clear got %b want 0", jump); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wait_cycle(3);  jump_src = 3'b001;
        wait_cycle(4);  jump_src = 3'b000;
        wait_cycle(5);  score = 7'd7;
        wait_cycle(11);
        checks++; if (high_score !== 7'd7) begin errors++; $display("FAIL mid_hs got %0d want 7", high_score); end
        wait_cycle(12); jump_src = 3'b001;
        wait_cycle(13); jump_src = 3'b000;
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL mid_jump got %b want 1", jump); end
        wait_cycle(15);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || jump !== 1'b0 || game_rst !== 1'b1 || frame_tick !== 1'b0 || high_score !== '0) begin
            errors++;
            $display("FAIL async_rst state %0d jump %b game_rst %b tick %b hs %0d want 0 0 1 0 0", state, jump, game_rst, frame_tick, high_score);
        end
        @(negedge clk);
        rst = 1'b0; score = '0;
        wait_cycle(9);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick9 got %b want 0", frame_tick); end
        wait_cycle(10);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL rst_tick10 got %b want 1", frame_tick); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            checks++;
            if (frame_tick !== m_tick || jump !== m_jump || state !== 2'(m_state) ||
                game_rst !== (m_state == 0) || high_score !== SW'(m_hs)) begin
                errors++;
                $display("FAIL random cycle %0d got tick %b jump %b state %0d game_rst %b hs %0d want %b %b %0d %b %0d",
                         m_n, frame_tick, jump, state, game_rst, high_score,
                         m_tick, m_jump, m_state, m_state == 0, m_hs);
            end
            if ($urandom_range(0, 99) == 0) src_sel = SELW'($urandom_range(0, 3));
            for (int b = 0; b < NS; b++) begin
                if ($urandom_range(0, 5) == 0) jump_src[b] = ~jump_src[b];
            end
            if (!is_collide && $urandom_range(0, 59) == 0) is_collide = 1'b1;
            else if (is_collide && $urandom_range(0, 7) == 0) is_collide = 1'b0;
            if ($urandom_range(0, 19) == 0) score = SW'($urandom_range(0, 127));
            @(negedge clk);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_start_jump();
`ifdef FLAPPY_AUTO_RESTART_EN
        test_auto_restart();
`else
        test_collide();
`endif
        test_src_switch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
